// File: rtl/frame_signature.sv
// -----------------------------------------------------------------------------
// frame_signature
//   Passive observer of the sprite/SVGA pixel stream. For every complete frame
//   it computes a CRC-16-CCITT signature (poly 16'h1021) over the 6-bit pixel
//   colours, MSB first, together with pixel and line counts. The results are
//   held until the readout side acknowledges them.
//
//   The first frame after reset or after re-enabling is partial and is never
//   captured. The FSM waits in SYNC for a frame boundary, then moves to RUN.
//
// Optional feature (macro FRAME_SIG_COMPARE_EN):
//   Adds a compare against expected_sig on every capture, giving a held
//   mismatch flag and a saturating mismatch counter.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   enable            arms signature generation
//   pixel_en          qualifies rrggbb this cycle
//   rrggbb [5:0]      pixel colour (0 during blanking)
//   next_vertical     pulse, last cycle of a line
//   next_frame        pulse, last cycle of a frame
//   sig [15:0]        CRC of last captured frame
//   pix_count         pixel count of last captured frame
//   line_count        line count of last captured frame
//   sig_valid         capture held and not yet acknowledged
//   sig_ack           clears sig_valid
//   overrun           sticky: a capture overwrote unacknowledged results
//   expected_sig, mismatch, mismatch_count   (FRAME_SIG_COMPARE_EN only)
// -----------------------------------------------------------------------------
module frame_signature #(
    parameter int          PIX_W    = 20,
    parameter int          LINE_W   = 10,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pixel_en,
    input  logic [5:0]        rrggbb,
    input  logic              next_vertical,
    input  logic              next_frame,
    output logic [15:0]       sig,
    output logic [PIX_W-1:0]  pix_count,
    output logic [LINE_W-1:0] line_count,
    output logic              sig_valid,
    input  logic              sig_ack,
`ifdef FRAME_SIG_COMPARE_EN
    input  logic [15:0]       expected_sig,
    output logic              mismatch,
    output logic [7:0]        mismatch_count,
`endif
    output logic              overrun
);

    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic {SYNC, RUN} state_t;

    state_t              state_q, state_d;
    logic [15:0]         crc_q, crc_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic [15:0]         sig_q, sig_d;
    logic [PIX_W-1:0]    pix_count_q, pix_count_d;
    logic [LINE_W-1:0]   line_count_q, line_count_d;
    logic                sig_valid_q, sig_valid_d;
    logic                overrun_q, overrun_d;
`ifdef FRAME_SIG_COMPARE_EN
    logic                mismatch_q, mismatch_d;
    logic [7:0]          mismatch_count_q, mismatch_count_d;
`endif

    // Six chained single-bit CRC steps; stage 0 consumes rrggbb[5].
    logic [15:0] crc_chain [0:6];
    assign crc_chain[0] = crc_q;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_crc_bit
            logic fb;
            assign fb = crc_chain[gi][15] ^ rrggbb[5-gi];
            assign crc_chain[gi+1] = {crc_chain[gi][14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    endgenerate

    // Running values including this cycle's pixel and line pulse.
    logic [15:0]       crc_upd;
    logic [PIX_W-1:0]  pix_upd;
    logic [LINE_W-1:0] line_upd;

    assign crc_upd  = pixel_en ? crc_chain[6] : crc_q;
    assign pix_upd  = pix_cnt_q + {{(PIX_W-1){1'b0}}, pixel_en};
    assign line_upd = line_cnt_q + {{(LINE_W-1){1'b0}}, next_vertical};

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        sig_d        = sig_q;
        pix_count_d  = pix_count_q;
        line_count_d = line_count_q;
        sig_valid_d  = sig_valid_q;
        overrun_d    = overrun_q;
`ifdef FRAME_SIG_COMPARE_EN
        mismatch_d       = mismatch_q;
        mismatch_count_d = mismatch_count_q;
`endif

        // An acknowledge without a capture drops the valid flag; a capture
        // in the same cycle overrides it below.
        if (sig_ack) begin
            sig_valid_d = 1'b0;
        end

        case (state_q)
            SYNC: begin
                // Running accumulators stay at their seed while waiting.
                crc_d      = CRC_INIT;
                pix_cnt_d  = '0;
                line_cnt_d = '0;
                if (enable && next_frame) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d    = SYNC;
                    crc_d      = CRC_INIT;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                end else if (next_frame) begin
                    sig_d        = crc_upd;
                    pix_count_d  = pix_upd;
                    line_count_d = line_upd;
                    // Overrun only when the previous result was never read.
                    if (sig_valid_q && !sig_ack) begin
                        overrun_d = 1'b1;
                    end
                    sig_valid_d = 1'b1;
                    crc_d       = CRC_INIT;
                    pix_cnt_d   = '0;
                    line_cnt_d  = '0;
`ifdef FRAME_SIG_COMPARE_EN
                    mismatch_d = (crc_upd != expected_sig);
                    if ((crc_upd != expected_sig) && (mismatch_count_q != 8'hFF)) begin
                        mismatch_count_d = mismatch_count_q + 8'd1;
                    end
`endif
                end else begin
                    crc_d      = crc_upd;
                    pix_cnt_d  = pix_upd;
                    line_cnt_d = line_upd;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYNC;
            crc_q        <= CRC_INIT;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            sig_q        <= '0;
            pix_count_q  <= '0;
            line_count_q <= '0;
            sig_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef FRAME_SIG_COMPARE_EN
            mismatch_q       <= 1'b0;
            mismatch_count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            sig_q        <= sig_d;
            pix_count_q  <= pix_count_d;
            line_count_q <= line_count_d;
            sig_valid_q  <= sig_valid_d;
            overrun_q    <= overrun_d;
`ifdef FRAME_SIG_COMPARE_EN
            mismatch_q       <= mismatch_d;
            mismatch_count_q <= mismatch_count_d;
`endif
        end
    end

    assign sig        = sig_q;
    assign pix_count  = pix_count_q;
    assign line_count = line_count_q;
    assign sig_valid  = sig_valid_q;
    assign overrun    = overrun_q;
`ifdef FRAME_SIG_COMPARE_EN
    assign mismatch       = mismatch_q;
    assign mismatch_count = mismatch_count_q;
`endif

endmodule

// File: tb/tb_frame_signature.sv
// -----------------------------------------------------------------------------
// tb_frame_signature
//   Directed bench for frame_signature. Expected CRC values are worked by
//   hand from seed 16'hFFFF with poly 16'h1021, MSB first:
//     pixel 6'b000000 -> 16'h387C
//     pixel 6'b111111 -> 16'hFFC0
//     pixel 6'b100000 -> 16'h1C1E
//     pixel 6'b000001 -> 16'h285D
//   The compare-feature checks are included when FRAME_SIG_COMPARE_EN is set.
// -----------------------------------------------------------------------------
module tb_frame_signature;

    localparam int PIX_W  = 20;
    localparam int LINE_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              pixel_en;
    logic [5:0]        rrggbb;
    logic              next_vertical;
    logic              next_frame;
    logic [15:0]       sig;
    logic [PIX_W-1:0]  pix_count;
    logic [LINE_W-1:0] line_count;
    logic              sig_valid;
    logic              sig_ack;
    logic              overrun;
`ifdef FRAME_SIG_COMPARE_EN
    logic [15:0]       expected_sig;
    logic              mismatch;
    logic [7:0]        mismatch_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_signature #(
        .PIX_W    (PIX_W),
        .LINE_W   (LINE_W),
        .CRC_INIT (16'hFFFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pixel_en      (pixel_en),
        .rrggbb        (rrggbb),
        .next_vertical (next_vertical),
        .next_frame    (next_frame),
        .sig           (sig),
        .pix_count     (pix_count),
        .line_count    (line_count),
        .sig_valid     (sig_valid),
        .sig_ack       (sig_ack),
`ifdef FRAME_SIG_COMPARE_EN
        .expected_sig  (expected_sig),
        .mismatch      (mismatch),
        .mismatch_count(mismatch_count),
`endif
        .overrun       (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic pe, input logic [5:0] pix, input logic nv,
                        input logic nf, input logic ack);
        pixel_en      = pe;
        rrggbb        = pix;
        next_vertical = nv;
        next_frame    = nf;
        sig_ack       = ack;
        @(posedge clk);
        #1;
        pixel_en      = 1'b0;
        rrggbb        = 6'd0;
        next_vertical = 1'b0;
        next_frame    = 1'b0;
        sig_ack       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 6'd0, 0, 0, 0);
        step(0, 6'd0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic show(input string name);
        $display("%-28s sig=%04h pix=%0d line=%0d valid=%0b overrun=%0b",
                 name, sig, pix_count, line_count, sig_valid, overrun);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pixel_en = 1'b0; rrggbb = 6'd0;
        next_vertical = 1'b0; next_frame = 1'b0; sig_ack = 1'b0;
`ifdef FRAME_SIG_COMPARE_EN
        expected_sig = 16'h387C;
`endif
        #1;
        do_reset();
        show("reset");
        chk("rst_sig",     32'(sig), 32'h0);
        chk("rst_pix",     32'(pix_count), 32'd0);
        chk("rst_line",    32'(line_count), 32'd0);
        chk("rst_valid",   32'(sig_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
`ifdef FRAME_SIG_COMPARE_EN
        chk("rst_mismatch",   32'(mismatch), 32'd0);
        chk("rst_mm_count",   32'(mismatch_count), 32'd0);
`endif

        // Empty frame: seed comes straight through.
        enable = 1'b1;
        step(0, 6'd0, 0, 1, 0);
        show("sync frame end");
        chk("sync_no_capture", 32'(sig_valid), 32'd0);
        step(0, 6'd0, 0, 1, 0);
        show("empty frame");
        chk("empty_sig",   32'(sig), 32'hFFFF);
        chk("empty_pix",   32'(pix_count), 32'd0);
        chk("empty_valid", 32'(sig_valid), 32'd1);
        step(0, 6'd0, 0, 0, 1);
        show("ack");
        chk("ack_clears", 32'(sig_valid), 32'd0);

        // Single zero pixel on the frame-end cycle.
        do_reset();
        enable = 1'b1;
        step(0, 6'd0, 0, 1, 0);
        step(1, 6'b000000, 0, 1, 0);
        show("one zero pixel");
        chk("zero_sig",  32'(sig), 32'h387C);
        chk("zero_pix",  32'(pix_count), 32'd1);
        chk("zero_line", 32'(line_count), 32'd0);
`ifdef FRAME_SIG_COMPARE_EN
        chk("cmp_match",       32'(mismatch), 32'd0);
        chk("cmp_match_count", 32'(mismatch_count), 32'd0);
`endif
        step(0, 6'd0, 0, 0, 1);

        // Bit order: rrggbb[5] is shifted first.
        step(1, 6'b100000, 0, 1, 0);
        show("pixel 100000");
        chk("msb_sig", 32'(sig), 32'h1C1E);
        step(0, 6'd0, 0, 0, 1);
        step(1, 6'b000001, 0, 1, 0);
        show("pixel 000001");
        chk("lsb_sig", 32'(sig), 32'h285D);
        step(0, 6'd0, 0, 0, 1);

        // A non-qualified pixel must not disturb crc or pixel count.
        step(1, 6'b111111, 0, 0, 0);
        step(0, 6'b101010, 0, 1, 0);
        show("pixel_en low on frame end");
        chk("hold_sig", 32'(sig), 32'hFFC0);
        chk("hold_pix", 32'(pix_count), 32'd1);
        chk("hold_overrun", 32'(overrun), 32'd0);
        step(0, 6'd0, 0, 0, 1);

        // Five pixels, three lines, frame end on the last pixel.
        do_reset();
        enable = 1'b1;
        step(0, 6'd0, 0, 1, 0);
        step(1, 6'd0, 0, 0, 0);
        step(1, 6'd0, 1, 0, 0);
        step(1, 6'd0, 0, 0, 0);
        step(1, 6'd0, 1, 0, 0);
        chk("lat_not_yet", 32'(sig_valid), 32'd0);
        step(1, 6'd0, 1, 1, 0);
        show("5 pixels 3 lines");
        chk("cnt_valid", 32'(sig_valid), 32'd1);
        chk("cnt_pix",   32'(pix_count), 32'd5);
        chk("cnt_line",  32'(line_count), 32'd3);

        // Second capture with no ack sets overrun and overwrites the results.
        step(1, 6'b111111, 0, 1, 0);
        show("capture without ack");
        chk("ovr_set",  32'(overrun), 32'd1);
        chk("ovr_sig",  32'(sig), 32'hFFC0);
        chk("ovr_pix",  32'(pix_count), 32'd1);
        chk("ovr_line", 32'(line_count), 32'd0);
        // Ack and capture together: capture wins.
        step(1, 6'b000000, 0, 1, 1);
        show("ack with capture");
        chk("ackcap_valid",   32'(sig_valid), 32'd1);
        chk("ackcap_sig",     32'(sig), 32'h387C);
        chk("ackcap_overrun", 32'(overrun), 32'd1);
        step(0, 6'd0, 0, 0, 1);
        show("ack only");
        chk("ack_valid_low",  32'(sig_valid), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Ack + capture while valid, from a clean state: overrun stays clear.
        do_reset();
        enable = 1'b1;
        step(0, 6'd0, 0, 1, 0);
        step(1, 6'b111111, 0, 1, 0);
        step(1, 6'b000000, 0, 1, 1);
        show("ack+capture no overrun");
        chk("ackcap_no_ovr", 32'(overrun), 32'd0);
        chk("ackcap_valid2", 32'(sig_valid), 32'd1);
        step(0, 6'd0, 0, 0, 1);

        // Disable mid-frame: the next frame end only resynchronises.
        step(1, 6'b111111, 0, 0, 0);
        enable = 1'b0;
        step(1, 6'b111111, 0, 0, 0);
        enable = 1'b1;
        step(1, 6'b000000, 0, 1, 0);
        show("re-enable sync frame");
        chk("reen_no_capture", 32'(sig_valid), 32'd0);
        chk("reen_sig_held",   32'(sig), 32'h387C);
        step(1, 6'b111111, 0, 1, 0);
        show("re-enable first frame");
        chk("reen_capture", 32'(sig_valid), 32'd1);
        chk("reen_sig",     32'(sig), 32'hFFC0);
        chk("reen_pix",     32'(pix_count), 32'd1);
        step(0, 6'd0, 0, 0, 1);

        // Reset mid-frame: the following frame is a sync frame.
        step(1, 6'b000001, 0, 0, 0);
        do_reset();
        enable = 1'b1;
        step(1, 6'd0, 0, 1, 0);
        show("frame after mid reset");
        chk("mreset_no_capture", 32'(sig_valid), 32'd0);
        chk("mreset_sig",        32'(sig), 32'h0);

`ifdef FRAME_SIG_COMPARE_EN
        expected_sig = 16'h0000;
        step(1, 6'b000000, 0, 1, 0);
        show("compare vs 0000");
        chk("cmp_mismatch",   32'(mismatch), 32'd1);
        chk("cmp_mm_count",   32'(mismatch_count), 32'd1);
        expected_sig = 16'h387C;
        step(1, 6'b000000, 0, 1, 1);
        show("compare vs 387C");
        chk("cmp_match_again", 32'(mismatch), 32'd0);
        chk("cmp_count_kept",  32'(mismatch_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
